// File: rtl/mmu_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mmu_lsu
// Brief    : Parametrised load/store unit between the CU and a single-port SRAM.
//            Optional macro MMU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
// Revision : 1.0
// ============================================================================
module mmu_lsu #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 128,
    parameter  int RD_LAT = 1,
    parameter  int WR_LAT = 1,
    localparam int NB     = DATA_W / 8,
    localparam int OW     = $clog2(NB),
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cu_start,
    input  logic              cu_mem_op,
    input  logic [1:0]        cu_size,
    input  logic              cu_unsigned,
    input  logic [31:0]       cu_base,
    input  logic [31:0]       cu_offset,
    input  logic [DATA_W-1:0] cu_dat_in,
    output logic [DATA_W-1:0] cu_dat_out,
    output logic              flg_busy,
    output logic              flg_complete,
    output logic              flg_error,
    output logic [AW-1:0]     sram_addr_sel,
    output logic [NB-1:0]     sram_byte_sel,
    output logic              sram_read_pulse,
    output logic              sram_write_pulse,
    output logic [DATA_W-1:0] sram_dat_in,
    input  logic [DATA_W-1:0] sram_dat_out
);

    localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_start_q;
    logic              r_op;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [AW-1:0]     r_word;
    logic [OW-1:0]     r_off;
    logic [DATA_W-1:0] r_data;
    logic [CW-1:0]     r_cnt;

    logic [31:0]       w_ea;
    logic [OW-1:0]     w_off_raw;
    logic [OW-1:0]     w_amask;
    logic [OW-1:0]     w_off_acc;
    logic              w_accept;
    logic              w_err_size;
    logic              w_err_range;
    logic              w_err;
    logic              w_last;
    logic              w_sign;
    logic [NB-1:0]     w_bsel;
    logic [DATA_W-1:0] w_wr_shift;
    logic [DATA_W-1:0] w_din;
    logic [DATA_W-1:0] w_rd_shift;
    logic [DATA_W-1:0] w_rd_ext;

    assign w_ea        = cu_base + cu_offset;
    assign w_off_raw   = w_ea[OW-1:0];
    assign w_accept    = (r_state == S_IDLE) && cu_start && !r_start_q;
    assign w_err_size  = int'(cu_size) > OW;
    assign w_err_range = {{OW{1'b0}}, w_ea[31:OW]} >= 32'(DEPTH);

    // Low cu_size bits of the lane offset must be zero for a naturally aligned access
    always_comb begin
        w_amask = '0;
        for (int i = 0; i < OW; i++)
            w_amask[i] = (i < int'(cu_size));
    end

`ifdef MMU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = |(w_off_raw & w_amask);
    assign w_err      = w_err_size | w_err_range | w_misalign;
    assign w_off_acc  = w_off_raw;
`else
    assign w_err      = w_err_size | w_err_range;
    assign w_off_acc  = w_off_raw & ~w_amask;
`endif

    always_comb begin
        w_bsel = '0;
        for (int i = 0; i < NB; i++)
            w_bsel[i] = (i >= int'(r_off)) && (i < int'(r_off) + (1 << r_size));
    end

    assign w_wr_shift = r_data << {r_off, 3'b000};
    assign w_rd_shift = sram_dat_out >> {r_off, 3'b000};

    always_comb begin
        w_din = '0;
        for (int i = 0; i < NB; i++)
            w_din[8*i +: 8] = w_bsel[i] ? w_wr_shift[8*i +: 8] : 8'h00;
    end

    // Truncate to the access width, then extend from its top bit
    always_comb begin
        w_sign   = 1'b0;
        w_rd_ext = '0;
        for (int b = 0; b < NB; b++)
            if (b == (1 << r_size) - 1)
                w_sign = w_rd_shift[8*b+7];
        for (int i = 0; i < DATA_W; i++)
            w_rd_ext[i] = (i < 8 * (1 << r_size)) ? w_rd_shift[i] : (w_sign & ~r_uns);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last           = 1'b0;
        flg_busy         = 1'b1;
        flg_complete     = 1'b0;
        flg_error        = 1'b0;
        sram_read_pulse  = 1'b0;
        sram_write_pulse = 1'b0;
        sram_addr_sel    = '0;
        sram_byte_sel    = '0;
        sram_dat_in      = '0;
        case (r_state)
            S_IDLE: begin
                flg_busy = 1'b0;
                if (w_accept)
                    w_state_nxt = w_err ? S_ERR : S_ISSUE;
            end
            S_ISSUE: begin
                sram_addr_sel    = r_word;
                sram_byte_sel    = w_bsel;
                sram_read_pulse  = !r_op;
                sram_write_pulse = r_op;
                sram_dat_in      = r_op ? w_din : '0;
                w_state_nxt      = S_WAIT;
            end
            S_WAIT: begin
                sram_addr_sel = r_word;
                sram_byte_sel = w_bsel;
                sram_dat_in   = r_op ? w_din : '0;
                if (r_cnt == CW'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                flg_complete = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            S_ERR: begin
                flg_complete = 1'b1;
                flg_error    = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q  <= 1'b0;
            r_op       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= '0;
            r_word     <= '0;
            r_off      <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            cu_dat_out <= '0;
        end else begin
            r_start_q <= cu_start;
            if (w_accept) begin
                r_op   <= cu_mem_op;
                r_uns  <= cu_unsigned;
                r_size <= cu_size;
                r_word <= w_ea[OW +: AW];
                r_off  <= w_off_acc;
                r_data <= cu_dat_in;
            end
            if (r_state == S_ISSUE)
                r_cnt <= r_op ? CW'(WR_LAT) : CW'(RD_LAT);
            else if (r_state == S_WAIT && r_cnt != '0)
                r_cnt <= r_cnt - CW'(1);
            if (w_last && !r_op)
                cu_dat_out <= w_rd_ext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmu_lsu.sv
`default_nettype none
// tb_mmu_lsu: directed checks on a 32-bit/latency-1 build (unit 0) and a
// 64-bit/read-latency-3/write-latency-2 build (unit 1), each with a small SRAM model.
module tb_mmu_lsu;

    localparam int D0_DEPTH = 128;
    localparam int D0_RL    = 1;
    localparam int D0_WL    = 1;
    localparam int D1_DEPTH = 64;
    localparam int D1_RL    = 3;
    localparam int D1_WL    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        op     = 1'b0;
    logic        uns    = 1'b0;
    logic [1:0]  size   = 2'd0;
    logic [31:0] base   = 32'd0;
    logic [31:0] offs   = 32'd0;
    logic [63:0] data   = 64'd0;

    logic [31:0] d0_dout, d0_sdi, d0_sdo;
    logic        d0_busy, d0_cmp, d0_err, d0_rp, d0_wp;
    logic [6:0]  d0_addr;
    logic [3:0]  d0_bsel;
    logic [63:0] d1_dout, d1_sdi, d1_sdo;
    logic        d1_busy, d1_cmp, d1_err, d1_rp, d1_wp;
    logic [5:0]  d1_addr;
    logic [7:0]  d1_bsel;

    mmu_lsu #(.DATA_W(32), .DEPTH(D0_DEPTH), .RD_LAT(D0_RL), .WR_LAT(D0_WL)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cu_start(start0), .cu_mem_op(op), .cu_size(size),
        .cu_unsigned(uns), .cu_base(base), .cu_offset(offs), .cu_dat_in(data[31:0]),
        .cu_dat_out(d0_dout), .flg_busy(d0_busy), .flg_complete(d0_cmp), .flg_error(d0_err),
        .sram_addr_sel(d0_addr), .sram_byte_sel(d0_bsel), .sram_read_pulse(d0_rp),
        .sram_write_pulse(d0_wp), .sram_dat_in(d0_sdi), .sram_dat_out(d0_sdo)
    );

    mmu_lsu #(.DATA_W(64), .DEPTH(D1_DEPTH), .RD_LAT(D1_RL), .WR_LAT(D1_WL)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cu_start(start1), .cu_mem_op(op), .cu_size(size),
        .cu_unsigned(uns), .cu_base(base), .cu_offset(offs), .cu_dat_in(data),
        .cu_dat_out(d1_dout), .flg_busy(d1_busy), .flg_complete(d1_cmp), .flg_error(d1_err),
        .sram_addr_sel(d1_addr), .sram_byte_sel(d1_bsel), .sram_read_pulse(d1_rp),
        .sram_write_pulse(d1_wp), .sram_dat_in(d1_sdi), .sram_dat_out(d1_sdo)
    );

    // SRAM models: read data is valid only in the cycle RD_LAT after the pulse
    logic [31:0] mem0 [D0_DEPTH];
    logic [63:0] mem1 [D1_DEPTH];
    logic [31:0] rd0_q = '0;
    logic [63:0] rd1_q = '0;
    int          rd0_cnt = 0;
    int          rd1_cnt = 0;

    always @(posedge clk) begin
        if (d0_rp) begin
            rd0_cnt <= D0_RL;
            rd0_q   <= mem0[d0_addr];
        end else if (rd0_cnt != 0) begin
            rd0_cnt <= rd0_cnt - 1;
        end
        if (d0_wp)
            for (int i = 0; i < 4; i++)
                if (d0_bsel[i]) mem0[d0_addr][8*i +: 8] <= d0_sdi[8*i +: 8];
    end

    always @(posedge clk) begin
        if (d1_rp) begin
            rd1_cnt <= D1_RL;
            rd1_q   <= mem1[d1_addr];
        end else if (rd1_cnt != 0) begin
            rd1_cnt <= rd1_cnt - 1;
        end
        if (d1_wp)
            for (int i = 0; i < 8; i++)
                if (d1_bsel[i]) mem1[d1_addr][8*i +: 8] <= d1_sdi[8*i +: 8];
    end

    assign d0_sdo = (rd0_cnt == 1) ? rd0_q : 32'hA5A5_A5A5;
    assign d1_sdo = (rd1_cnt == 1) ? rd1_q : 64'hA5A5_A5A5_A5A5_A5A5;

    bit          unit = 1'b0;
    logic [63:0] v_dout, v_sdi;
    logic        v_busy, v_cmp, v_err, v_rp, v_wp;
    logic [31:0] v_addr;
    logic [7:0]  v_bsel;

    always_comb begin
        if (unit) begin
            v_dout = d1_dout;         v_sdi = d1_sdi;
            v_busy = d1_busy;         v_cmp = d1_cmp;  v_err = d1_err;
            v_rp   = d1_rp;           v_wp  = d1_wp;
            v_addr = {26'd0, d1_addr}; v_bsel = d1_bsel;
        end else begin
            v_dout = {32'd0, d0_dout}; v_sdi = {32'd0, d0_sdi};
            v_busy = d0_busy;          v_cmp = d0_cmp;  v_err = d0_err;
            v_rp   = d0_rp;            v_wp  = d0_wp;
            v_addr = {25'd0, d0_addr}; v_bsel = {4'd0, d0_bsel};
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] last_dout [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // exp_val: sram_dat_in for a write, cu_dat_out for a read
    task automatic access(input bit u, input bit w, input logic [1:0] sz, input bit un,
                          input logic [31:0] b, input logic [31:0] o, input logic [63:0] d,
                          input bit exp_err, input int exp_addr, input logic [7:0] exp_bsel,
                          input logic [63:0] exp_val);
        int lat;
        bit done;
        lat = u ? (w ? D1_WL : D1_RL) : (w ? D0_WL : D0_RL);
        @(negedge clk);
        unit = u; op = w; size = sz; uns = un; base = b; offs = o; data = d;
        if (u) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        if (exp_err) begin
            check("err_cmp", v_cmp, 1);
            check("err_flag", v_err, 1);
            check("err_busy", v_busy, 1);
            check("err_pulse", {v_rp, v_wp}, 0);
            @(negedge clk);
            check("err_end", {v_busy, v_cmp, v_err}, 0);
        end else begin
            check("pulse", {v_rp, v_wp}, w ? 2'b01 : 2'b10);
            check("addr", v_addr, exp_addr);
            check("bsel", v_bsel, exp_bsel);
            if (w) check("sram_dat_in", v_sdi, exp_val);
            done = 1'b0;
            for (int k = 2; k < 12 && !done; k++) begin
                @(negedge clk);
                if (v_cmp) begin
                    done = 1'b1;
                    check("cmp_cycle", k, 2 + lat);
                    check("cmp_err", v_err, 0);
                    check("dout", v_dout, w ? last_dout[u] : exp_val);
                    if (!w) last_dout[u] = exp_val;
                end else begin
                    check("wait_addr", v_addr, exp_addr);
                    check("wait_nopulse", {v_rp, v_wp}, 0);
                end
            end
            check("cmp_timeout", done, 1);
            @(negedge clk);
            check("idle", v_busy, 0);
        end
    endtask

    initial begin
        int np, nc;
        last_dout[0] = '0;
        last_dout[1] = '0;
        #1;
        check("rst_d0_flags", {d0_busy, d0_cmp, d0_err, d0_rp, d0_wp, d0_bsel, d0_addr}, 0);
        check("rst_d0_data", {d0_dout, d0_sdi}, 0);
        check("rst_d1_flags", {d1_busy, d1_cmp, d1_err, d1_rp, d1_wp, d1_bsel, d1_addr}, 0);
        check("rst_d1_data", d1_dout | d1_sdi, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---- unit 0: 32-bit, latency 1 ----
        access(0, 1, 2'd2, 0, 32'h10, 32'h4, 64'hDEADBEEF, 0, 5, 8'h0F, 64'hDEADBEEF);
        access(0, 0, 2'd0, 0, 32'h10, 32'h6, 64'h0, 0, 5, 8'h04, 64'hFFFFFFAD);
        access(0, 0, 2'd0, 1, 32'h10, 32'h6, 64'h0, 0, 5, 8'h04, 64'h000000AD);
`ifdef MMU_MISALIGN_TRAP_EN
        access(0, 1, 2'd1, 0, 32'h10, 32'h5, 64'hABCD1234, 1, 0, 8'h00, 64'h0);
        access(0, 0, 2'd1, 0, 32'h10, 32'h6, 64'h0, 0, 5, 8'h0C, 64'hFFFFDEAD);
        access(0, 0, 2'd2, 1, 32'h14, 32'h0, 64'h0, 0, 5, 8'h0F, 64'hDEADBEEF);
`else
        access(0, 1, 2'd1, 0, 32'h10, 32'h5, 64'hABCD1234, 0, 5, 8'h03, 64'h00001234);
        access(0, 0, 2'd1, 0, 32'h10, 32'h6, 64'h0, 0, 5, 8'h0C, 64'hFFFFDEAD);
        access(0, 0, 2'd2, 1, 32'h14, 32'h0, 64'h0, 0, 5, 8'h0F, 64'hDEAD1234);
`endif
        access(0, 1, 2'd0, 0, 32'h20, 32'hFFFFFFFF, 64'h80, 0, 7, 8'h08, 64'h80000000);
        access(0, 0, 2'd0, 0, 32'h20, 32'hFFFFFFFF, 64'h0, 0, 7, 8'h08, 64'hFFFFFF80);
        access(0, 0, 2'd2, 0, 32'h100, 32'h100, 64'h0, 1, 0, 8'h00, 64'h0);
        access(0, 1, 2'd2, 0, 32'h0, 32'hFFFFFFFC, 64'h1, 1, 0, 8'h00, 64'h0);
        access(0, 0, 2'd3, 0, 32'h0, 32'h0, 64'h0, 1, 0, 8'h00, 64'h0);
        access(0, 1, 2'd2, 0, 32'h1FC, 32'h0, 64'h0BADF00D, 0, 127, 8'h0F, 64'h0BADF00D);
        access(0, 0, 2'd0, 1, 32'h1FC, 32'h3, 64'h0, 0, 127, 8'h08, 64'h0000000B);

        // start held high for many cycles must produce a single access
        @(negedge clk);
        unit = 0; op = 1; size = 2'd2; uns = 0; base = 32'h40; offs = 0; data = 64'h11223344;
        start0 = 1'b1;
        np = 0; nc = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            np += int'(v_wp);
            nc += int'(v_cmp);
            if (i == 9) start0 = 1'b0;
        end
        check("hold_pulses", np, 1);
        check("hold_cmp", nc, 1);

        // ---- unit 1: 64-bit, read latency 3, write latency 2 ----
        access(1, 1, 2'd3, 0, 32'h0, 32'h8, 64'h8877665544332211, 0, 1, 8'hFF, 64'h8877665544332211);
        access(1, 0, 2'd2, 0, 32'h10, 32'hFFFFFFFC, 64'h0, 0, 1, 8'hF0, 64'hFFFFFFFF88776655);
        access(1, 0, 2'd1, 1, 32'h8, 32'h6, 64'h0, 0, 1, 8'hC0, 64'h0000000000008877);
        access(1, 1, 2'd0, 0, 32'h8, 32'h3, 64'h5A, 0, 1, 8'h08, 64'h000000005A000000);
        access(1, 0, 2'd3, 0, 32'h8, 32'h0, 64'h0, 0, 1, 8'hFF, 64'h887766555A332211);
`ifdef MMU_MISALIGN_TRAP_EN
        access(1, 0, 2'd2, 0, 32'h8, 32'h6, 64'h0, 1, 0, 8'h00, 64'h0);
`else
        access(1, 0, 2'd2, 0, 32'h8, 32'h6, 64'h0, 0, 1, 8'hF0, 64'hFFFFFFFF88776655);
`endif
        access(1, 0, 2'd2, 0, 32'h200, 32'h0, 64'h0, 1, 0, 8'h00, 64'h0);

        // a second start edge while waiting must be ignored
        @(negedge clk);
        unit = 1; op = 0; size = 2'd0; uns = 1; base = 32'h8; offs = 32'h3;
        start1 = 1'b1;
        np = 0; nc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            np += int'(v_rp) + int'(v_wp);
            nc += int'(v_cmp);
            if (i == 0) start1 = 1'b0;
            if (i == 1) start1 = 1'b1;
            if (i == 2) start1 = 1'b0;
        end
        check("edge_pulses", np, 1);
        check("edge_cmp", nc, 1);
        check("edge_dout", v_dout, 64'h5A);
        last_dout[1] = 64'h5A;

        // asynchronous reset in the middle of the wait
        @(negedge clk);
        unit = 1; op = 0; size = 2'd3; uns = 0; base = 32'h8; offs = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("rst_issue_pulse", v_rp, 1);
        @(negedge clk);
        check("rst_wait_busy", v_busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {v_busy, v_cmp, v_err, v_rp, v_wp}, 0);
        check("rst_mid_addr", {v_addr, v_bsel}, 0);
        check("rst_mid_dout", v_dout, 0);
        last_dout[0] = '0;
        last_dout[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        np = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            np += int'(v_cmp) + int'(v_rp);
        end
        check("rst_no_cmp", np, 0);
        access(1, 0, 2'd3, 0, 32'h8, 32'h0, 64'h0, 0, 1, 8'hFF, 64'h887766555A332211);
        access(0, 0, 2'd2, 0, 32'h14, 32'h0, 64'h0, 0, 5, 8'h0F,
`ifdef MMU_MISALIGN_TRAP_EN
               64'hDEADBEEF);
`else
               64'hDEAD1234);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
